clk_div_gen: RTL and testbench
==============================

CLK_DIV_GEN -- requirements
Module: clk_div_gen

Interface
REQ-001 Parameter CW, default 16, meaning width of the divisor and phase counter in bits.
REQ-002 Parameter DIV_RESET, default 4, meaning the divisor in force after reset; legal range 2..2^CW-1.
REQ-003 Port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 Port rst  input  1  reset, asynchronous and active-high.
REQ-005 Port en  input  1  count enable; when 0, all divider state holds.
REQ-006 Port div_val  input  CW  requested divisor.
REQ-007 Port div_load  input  1  single-cycle strobe that captures div_val.
REQ-008 Port div_out  output  1  registered divided clock.
REQ-009 Port tick  output  1  registered one-cycle pulse at the start of each output period.
REQ-010 Port div_pending  output  1  high while a captured divisor awaits application.
REQ-011 Port phase  output  CW  current phase count, 0..D-1.

Function
REQ-012 The block SHALL hold an active divisor D, a pending divisor P and a phase counter cnt, all CW bits wide.
REQ-013 On each clk edge with en=1, cnt SHALL advance to cnt+1, or wrap to 0 when cnt==D-1.
REQ-014 div_out SHALL equal 1 exactly when cnt < H, where H=(D+1)>>1: 50% duty for even D, one extra high cycle for odd D.
REQ-015 tick SHALL be 1 for exactly the cycle in which cnt==0 following an enabled wrap; otherwise it SHALL be 0.
REQ-016 div_out, tick and phase SHALL come from registers with no combinational path from inputs.
REQ-017 On div_load=1, div_val SHALL be captured into P and div_pending SHALL be set; a value below 2 SHALL be clamped to 2.
REQ-018 A div_load while div_pending=1 SHALL overwrite P (last write wins).
REQ-019 At an enabled wrap with div_pending=1, D SHALL take P and div_pending SHALL clear in the same edge.
REQ-020 A div_load in the same cycle as an enabled wrap SHALL apply the clamped div_val directly as D at that wrap and leave div_pending=0.
REQ-021 D SHALL never change except at a wrap, so cnt never exceeds D-1 and no runt period is produced.
REQ-022 With en=0, cnt, D, div_out SHALL hold and tick SHALL be 0.
REQ-023 With en=0, loads SHALL still be captured; they SHALL be applied at the first enabled wrap.
REQ-024 H and the wrap compare SHALL be computed from the new D on the wrap edge, so the first new period has the new shape.

Reset
REQ-025 While rst=1, the block SHALL hold D=DIV_RESET, P=DIV_RESET, cnt=DIV_RESET-1, div_out=0, tick=0 and div_pending=0.
REQ-026 The first enabled edge after rst deasserts SHALL wrap cnt to 0 and produce tick=1 and div_out=1.
REQ-027 rst asserted mid-period SHALL discard any pending divisor immediately.

Structure
REQ-028 A shared package/header SHALL hold DIV_MIN=2 and the default CW; the block SHALL use DIV_MIN for clamping.
REQ-029 The divisor capture, clamp and pending/apply logic SHALL be a sub-module named clk_div_ctrl.
REQ-030 The counter, div_out and tick SHALL be in the top module.

Verification
REQ-031 Reset, then en=1 with DIV_RESET=4 -> div_out pattern 1,1,0,0 repeating; tick every 4th cycle; first tick on the first enabled edge.
REQ-032 Load div_val=5 mid-period, then en=1 -> current 4-cycle period completes; then div_out 1,1,1,0,0 with tick at the new period start; div_pending high from the load until that wrap.
REQ-033 Load 6 then 3 before the wrap -> only the divisor 3 is applied (pattern 1,1,0); a div_load coincident with the wrap applies with div_pending never asserting.
REQ-034 Load div_val=0 and div_val=1 -> D=2, pattern 1,0, tick every 2 cycles.
REQ-035 en=0 for 7 cycles mid-period with a load during the gap -> phase and div_out frozen, tick=0, divisor applied at the first enabled wrap.
REQ-036 Assert rst mid-period with div_pending=1 -> outputs at reset values immediately; pending discarded; after release, DIV_RESET pattern resumes.

Source files
------------

// File: rtl/clk_div_gen_pkg.sv
// Shared constants for the programmable clock divider.
package clk_div_gen_pkg;
  localparam int unsigned CW_DEFAULT = 16;
  localparam int unsigned DIV_MIN    = 2;
endpackage

// File: rtl/clk_div_gen_ctrl.sv
// Divisor capture, clamp and pending/apply control for clk_div_gen.
module clk_div_ctrl
  import clk_div_gen_pkg::*;
#(
  parameter int unsigned CW        = CW_DEFAULT,
  parameter int unsigned DIV_RESET = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          wrap_i,
  input  logic [CW-1:0] div_val_i,
  input  logic          div_load_i,
  output logic [CW-1:0] div_o,
  output logic [CW-1:0] div_next_o,
  output logic          pending_o
);

  logic [CW-1:0] div_q, div_d;
  logic [CW-1:0] pend_div_q, pend_div_d;
  logic          pending_q, pending_d;
  logic [CW-1:0] clamped;

  always_comb begin
    clamped = (div_val_i < CW'(DIV_MIN)) ? CW'(DIV_MIN) : div_val_i;
  end

  // A load coinciding with a wrap bypasses the pending register entirely.
  always_comb begin
    div_d      = div_q;
    pend_div_d = pend_div_q;
    pending_d  = pending_q;
    if (wrap_i) begin
      pending_d = 1'b0;
      if (div_load_i) begin
        div_d = clamped;
      end else if (pending_q) begin
        div_d = pend_div_q;
      end
    end else if (div_load_i) begin
      pend_div_d = clamped;
      pending_d  = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      div_q      <= CW'(DIV_RESET);
      pend_div_q <= CW'(DIV_RESET);
      pending_q  <= 1'b0;
    end else begin
      div_q      <= div_d;
      pend_div_q <= pend_div_d;
      pending_q  <= pending_d;
    end
  end

  assign div_o      = div_q;
  assign div_next_o = div_d;
  assign pending_o  = pending_q;

endmodule

// File: rtl/clk_div_gen.sv
// Programmable clock divider: phase counter, divided clock and period tick.
module clk_div_gen
  import clk_div_gen_pkg::*;
#(
  parameter int unsigned CW        = CW_DEFAULT,
  parameter int unsigned DIV_RESET = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [CW-1:0] div_val,
  input  logic          div_load,
  output logic          div_out,
  output logic          tick,
  output logic          div_pending,
  output logic [CW-1:0] phase
);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          out_q, out_d;
  logic          tick_q, tick_d;
  logic [CW-1:0] div_cur, div_next;
  logic          wrap;
  logic [CW:0]   half;

  clk_div_ctrl #(
    .CW        (CW),
    .DIV_RESET (DIV_RESET)
  ) u_ctrl (
    .clk_i      (clk),
    .rst_i      (rst),
    .wrap_i     (wrap),
    .div_val_i  (div_val),
    .div_load_i (div_load),
    .div_o      (div_cur),
    .div_next_o (div_next),
    .pending_o  (div_pending)
  );

  assign wrap = en && (cnt_q == (div_cur - CW'(1)));

  // High-phase length uses the divisor in force for the next cycle, so a new
  // divisor shapes its very first period; CW+1 bits avoid overflow at max D.
  assign half = ({1'b0, div_next} + (CW+1)'(1)) >> 1;

  always_comb begin
    cnt_d  = cnt_q;
    out_d  = out_q;
    tick_d = 1'b0;
    if (en) begin
      cnt_d  = wrap ? '0 : cnt_q + CW'(1);
      out_d  = ({1'b0, cnt_d} < half);
      tick_d = wrap;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= CW'(DIV_RESET - 1);
      out_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      out_q  <= out_d;
      tick_q <= tick_d;
    end
  end

  assign div_out = out_q;
  assign tick    = tick_q;
  assign phase   = cnt_q;

endmodule

// File: tb/tb_clk_div_gen.sv
// Self-checking bench for clk_div_gen: directed scenarios plus random traffic.
module tb_clk_div_gen;

  localparam int CW      = 16;
  localparam int RST_DIV = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [CW-1:0] div_val;
  logic          div_load;
  logic          div_out;
  logic          tick;
  logic          div_pending;
  logic [CW-1:0] phase;

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  clk_div_gen #(
    .CW        (CW),
    .DIV_RESET (RST_DIV)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .div_val     (div_val),
    .div_load    (div_load),
    .div_out     (div_out),
    .tick        (tick),
    .div_pending (div_pending),
    .phase       (phase)
  );

  always #5 clk = ~clk;

  // Reference: period length m_d, position m_cnt within it; high for the
  // first ceil(D/2) positions, i.e. while 2*pos < D.
  int m_d    = RST_DIV;
  int m_p    = RST_DIV;
  int m_cnt  = RST_DIV - 1;
  bit m_out  = 1'b0;
  bit m_tick = 1'b0;
  bit m_pend = 1'b0;
  int m_req;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_d = RST_DIV; m_p = RST_DIV; m_cnt = RST_DIV - 1;
      m_out = 1'b0; m_tick = 1'b0; m_pend = 1'b0;
    end else begin
      m_req = (int'(div_val) < 2) ? 2 : int'(div_val);
      if (en && (m_cnt == m_d - 1)) begin
        if (div_load) m_d = m_req;
        else if (m_pend) m_d = m_p;
        m_pend = 1'b0;
        m_cnt  = 0;
        m_tick = 1'b1;
      end else begin
        if (div_load) begin
          m_p = m_req;
          m_pend = 1'b1;
        end
        m_tick = 1'b0;
        if (en) m_cnt = m_cnt + 1;
      end
      m_out = (2 * m_cnt < m_d);
    end
  end

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      check("model_div_out", int'(div_out), int'(m_out));
      check("model_tick", int'(tick), int'(m_tick));
      check("model_phase", int'(phase), m_cnt);
      check("model_pending", int'(div_pending), int'(m_pend));
    end
  end

  // Inputs change 3 time units after a rising edge; returns at the same offset
  // after the following edge so outputs of that edge can be inspected.
  task automatic cyc(input logic e, input logic ld, input int v);
    en = e;
    div_load = ld;
    div_val = CW'(v);
    @(posedge clk);
    #3;
    div_load = 1'b0;
  endtask

  task automatic lit(input string nm, input bit eo, input bit et);
    check({nm, "_out"}, int'(div_out), int'(eo));
    check({nm, "_tick"}, int'(tick), int'(et));
  endtask

  initial begin
    bit p4_out [8];
    bit p4_tick[8];
    bit p5_out [5];
    bit p3_out [3];
    p4_out  = '{1, 1, 0, 0, 1, 1, 0, 0};
    p4_tick = '{1, 0, 0, 0, 1, 0, 0, 0};
    p5_out  = '{1, 1, 1, 0, 0};
    p3_out  = '{1, 1, 0};

    rst = 1'b1; en = 1'b0; div_load = 1'b0; div_val = '0;
    repeat (2) @(posedge clk);
    #3;
    check("rst_phase", int'(phase), RST_DIV - 1);
    check("rst_div_out", int'(div_out), 0);
    check("rst_tick", int'(tick), 0);
    check("rst_pending", int'(div_pending), 0);
    rst = 1'b0;
    chk_on = 1'b1;

    // Default divisor 4
    for (int i = 0; i < 8; i++) begin
      cyc(1, 0, 0);
      lit("d4", p4_out[i], p4_tick[i]);
    end

    // Load 5 mid-period
    cyc(1, 0, 0);
    cyc(1, 1, 5);
    check("ld5_pending", int'(div_pending), 1);
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    check("ld5_still_pending", int'(div_pending), 1);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, 0);
      lit("d5", p5_out[i], i == 0);
    end
    check("d5_pending_clear", int'(div_pending), 0);

    // Load 6 then 3: last write wins
    cyc(1, 0, 0);
    cyc(1, 1, 6);
    cyc(1, 1, 3);
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0);
      lit("d3", p3_out[i], i == 0);
    end
    // Load coincident with wrap: applied directly, pending never rises
    cyc(1, 1, 8);
    lit("coinc8", 1, 1);
    check("coinc8_pending", int'(div_pending), 0);
    for (int i = 1; i < 8; i++) begin
      cyc(1, 0, 0);
      check("coinc8_phase", int'(phase), i);
    end

    // Clamp 0 and 1 to 2
    cyc(1, 1, 0);
    lit("d2", 1, 1);
    cyc(1, 1, 1);
    lit("d2", 0, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(1, 0, 0);
      lit("d2", (i % 2) == 0, (i % 2) == 0);
    end

    // Enable gap with a load inside it
    cyc(1, 1, 6);
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    for (int i = 0; i < 7; i++) begin
      cyc(0, i == 2, 3);
      check("gap_phase", int'(phase), 2);
      lit("gap", 1, 0);
    end
    check("gap_pending", int'(div_pending), 1);
    repeat (3) cyc(1, 0, 0);
    check("gap_phase_end", int'(phase), 5);
    cyc(1, 0, 0);
    lit("gap_apply", 1, 1);
    check("gap_apply_pending", int'(div_pending), 0);

    // Asynchronous reset mid-period with a pending divisor
    cyc(1, 1, 9);
    cyc(1, 0, 0);
    check("pre_rst_pending", int'(div_pending), 1);
    rst = 1'b1;
    #1;
    check("arst_phase", int'(phase), RST_DIV - 1);
    check("arst_div_out", int'(div_out), 0);
    check("arst_tick", int'(tick), 0);
    check("arst_pending", int'(div_pending), 0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cyc(1, 0, 0);
      lit("post_rst", p4_out[i], p4_tick[i]);
    end

    // Random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      int v;
      v = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 1)) : int'($urandom_range(2, 24));
      if ($urandom_range(0, 299) == 0) begin
        rst = 1'b1;
        cyc($urandom_range(0, 1), 0, 0);
        rst = 1'b0;
      end else begin
        cyc($urandom_range(0, 6) != 0, $urandom_range(0, 11) == 0, v);
      end
    end

    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
